mem_ctrl: RTL and testbench
===========================

# mem_ctrl

Memory controller between the core and the byte-wide RAM/IO bus: the responder end of the load/store buffer's memory request port and of the instruction-fetch port. Serialises each request into 1/2/4 single-byte RAM transactions (little-endian), assembles or extends read data, and returns a one-cycle completion pulse. Executes one request at a time; arbitrates LSB over fetch.

## Interface
- No parameters; widths and opcodes come from `utils.v` (`ADDR_RANGE`/`DATA_RANGE` = [31:0], `OPT_RANGE`, `LB` `LH` `LW` `LBU` `LHU` `SB` `SH` `SW`).
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- rdy  in  1  when low, all state and outputs hold
- rollback_from_rob  in  1  misprediction flush
- io_buffer_full  in  1  UART FIFO full; gates writes to IO space
- mem_din  in  8  RAM read byte (for address driven in previous cycle)
- mem_dout  out  8  RAM write byte
- mem_a  out  32  RAM byte address
- mem_wr  out  1  1 = write, 0 = read
- valid_from_lsb  in  1  LSB request; held high until the response pulse is seen
- inst_type_from_lsb  in  `OPT_RANGE`  load/store opcode
- addr_from_lsb  in  32  byte address
- data_from_lsb  in  32  store data (low bytes used)
- valid_to_lsb  out  1  one-cycle completion pulse
- data_to_lsb  out  32  load result (0 for stores)
- valid_from_ifetch  in  1  fetch request; held until response
- addr_from_ifetch  in  32  fetch address
- valid_to_ifetch  out  1  one-cycle completion pulse
- inst_to_ifetch  out  32  fetched word

## Operation
- States: IDLE, READ, WRITE, DONE. Registers: latched addr, opcode, store data, source (LSB/IF), byte count n, byte index, 32-bit assembly buffer.
- IDLE: sample valid_from_lsb, else valid_from_ifetch; latch request, index=0. LSB wins when both high; fetch keeps waiting. n = 1 (LB/LBU/SB), 2 (LH/LHU/SH), 4 (LW/SW/fetch). Load/fetch -> READ, store -> WRITE.
- READ: drive mem_a=addr+index, mem_wr=0 for indices 0..n-1; byte i captured from mem_din the cycle after its address into buffer bits [8i+7:8i]. After byte n-1 captured -> DONE.
- WRITE: drive mem_a=addr+index, mem_dout=data[8i+7:8i], mem_wr=1, index++; after byte n-1 -> DONE. If addr[17:16]==2'b11 and io_buffer_full=1: mem_wr=0, index holds, retry next cycle.
- DONE: exactly one cycle; pulse valid_to_lsb or valid_to_ifetch; no new request sampled (requester drops valid at this edge); -> IDLE.
- Result: LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW/fetch full word; stores return data_to_lsb=0.
- Address arithmetic is 32-bit wrapping; no alignment check.
- rollback_from_rob (sampled at edge): READ or DONE of any source -> IDLE, no pulse, mem_wr=0; WRITE completes normally (committed store). Requests are not sampled on a rollback edge.
- rst: state IDLE; mem_wr=0, mem_a=0, mem_dout=0, valid_to_lsb=0, valid_to_ifetch=0, data_to_lsb=0, inst_to_ifetch=0. Mid-transaction reset discards it immediately.

## Timing
- All outputs registered. Request sampled at edge T0; cycles after T0 numbered 1, 2, ...
- Read of n bytes: byte i address in cycle 1+i, data in cycle 2+i; pulse in cycle n+2 (LW/fetch: cycle 6, LB: cycle 3).
- Write of n bytes (no stall): byte i written in cycle 1+i; pulse in cycle n+1 (SW: cycle 5, SB: cycle 2); each stalled cycle adds one.
- Back-to-back: next request sampled earliest at the edge ending the cycle after the pulse.
- mem_wr=0 in every cycle not actively writing; rdy low freezes the cycle count.

## Test plan
- RAM[0x100..0x103]=78 56 34 12; LSB LW 0x100 -> mem_a 0x100..0x103 in cycles 1-4, valid_to_lsb in cycle 6, data_to_lsb=0x12345678; pulse exactly one cycle, no re-issue.
- RAM[0x200]=0x80: LB -> 0xFFFFFF80; LBU -> 0x00000080; LH with RAM[0x201]=0xFF -> 0xFFFFFF80.
- SH addr 0x300 data 0xAABBCCDD -> writes DD@0x300 cycle 1, CC@0x301 cycle 2, pulse cycle 3; 0x302 untouched.
- LSB and fetch both valid in IDLE -> LSB served first; fetch 0x0 served after LSB pulse, inst_to_ifetch correct.
- Fetch in progress, rollback in cycle 3 -> no valid_to_ifetch, returns IDLE; SW with rollback in cycle 2 -> all 4 bytes written, pulse delivered.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr stays 0, write occurs on first cycle after release, pulse next cycle; rst asserted mid-LW -> all outputs 0 immediately, no pulse.

Source files
------------

// File: rtl/mem_ctrl.sv
// ---------------------------------------------------------------------------
// mem_ctrl
// Memory controller between the core and a byte-wide RAM/IO bus. It answers
// the load/store buffer (LSB) request port and the instruction-fetch port,
// one request at a time, with the LSB winning when both ask in the same cycle.
// Each request is serialised into 1, 2 or 4 single-byte RAM cycles
// (little-endian). Read bytes are assembled and sign/zero extended, and the
// requester gets a one-cycle completion pulse.
//
// Ports
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   rdy                 low: every register (state and outputs) holds
//   rollback_from_rob   flush: aborts reads and pending responses, not writes
//   io_buffer_full      UART FIFO full; stalls writes into IO space (addr[17:16]==2'b11)
//   mem_din/mem_dout    RAM read byte (for last cycle's address) / write byte
//   mem_a, mem_wr       RAM byte address, 1 = write
//   *_from_lsb          LSB request: valid, opcode, address, store data
//   valid/data_to_lsb   LSB completion pulse and load result (0 for stores)
//   *_from_ifetch       fetch request: valid, address
//   valid/inst_to_ifetch fetch completion pulse and fetched word
// ---------------------------------------------------------------------------
module mem_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        rollback_from_rob,
    input  logic        io_buffer_full,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        valid_from_lsb,
    input  logic [3:0]  inst_type_from_lsb,
    input  logic [31:0] addr_from_lsb,
    input  logic [31:0] data_from_lsb,
    output logic        valid_to_lsb,
    output logic [31:0] data_to_lsb,
    input  logic        valid_from_ifetch,
    input  logic [31:0] addr_from_ifetch,
    output logic        valid_to_ifetch,
    output logic [31:0] inst_to_ifetch
);

    // Load/store opcodes shared with the LSB.
    localparam logic [3:0] LB  = 4'd0;
    localparam logic [3:0] LH  = 4'd1;
    localparam logic [3:0] LW  = 4'd2;
    localparam logic [3:0] LBU = 4'd3;
    localparam logic [3:0] LHU = 4'd4;
    localparam logic [3:0] SB  = 4'd5;
    localparam logic [3:0] SH  = 4'd6;
    localparam logic [3:0] SW  = 4'd7;

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    function automatic logic [2:0] nbytes(input logic [3:0] op);
        case (op)
            LB, LBU, SB: nbytes = 3'd1;
            LH, LHU, SH: nbytes = 3'd2;
            default:     nbytes = 3'd4;
        endcase
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        is_store = (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic logic [31:0] extend(input logic [3:0] op, input logic [31:0] w);
        case (op)
            LB:      extend = {{24{w[7]}}, w[7:0]};
            LH:      extend = {{16{w[15]}}, w[15:0]};
            LBU:     extend = {24'd0, w[7:0]};
            LHU:     extend = {16'd0, w[15:0]};
            default: extend = w;
        endcase
    endfunction

    state_t      r_state, w_next_state;
    logic [31:0] r_addr, r_data, r_buf;
    logic [3:0]  r_op;
    logic        r_is_lsb;
    logic [2:0]  r_n, r_idx;

    // Incoming request, LSB has priority; a fetch is handled as a plain LW.
    logic        w_take, w_req_store;
    logic [31:0] w_req_addr;
    logic [3:0]  w_req_op;
    logic [1:0]  w_io_page;
    logic        w_io_stall;

    assign w_take      = (valid_from_lsb || valid_from_ifetch) && !rollback_from_rob;
    assign w_req_addr  = valid_from_lsb ? addr_from_lsb : addr_from_ifetch;
    assign w_req_op    = valid_from_lsb ? inst_type_from_lsb : LW;
    assign w_req_store = valid_from_lsb && is_store(inst_type_from_lsb);
    // The byte about to be launched belongs to the new request while idle.
    assign w_io_page   = (r_state == IDLE) ? w_req_addr[17:16] : r_addr[17:16];
    assign w_io_stall  = io_buffer_full && (w_io_page == 2'b11);

    // Next-register values computed by the output process.
    logic [31:0] w_mem_a_nx, w_data_to_lsb_nx, w_inst_nx, w_buf_nx, w_buf_cap;
    logic [7:0]  w_mem_dout_nx, w_wr_byte;
    logic        w_mem_wr_nx, w_valid_lsb_nx, w_valid_if_nx;
    logic [2:0]  w_idx_nx;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst)
            r_state <= IDLE;
        else if (rdy)
            r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_take) w_next_state = w_req_store ? WRITE : READ;
            READ:    if (rollback_from_rob) w_next_state = IDLE;
                     else if (r_idx == r_n) w_next_state = DONE;
            WRITE:   if (r_idx == r_n) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Output / datapath logic: next values for the registered outputs.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        w_mem_a_nx       = mem_a;
        w_mem_dout_nx    = mem_dout;
        w_mem_wr_nx      = 1'b0;
        w_valid_lsb_nx   = 1'b0;
        w_valid_if_nx    = 1'b0;
        w_data_to_lsb_nx = data_to_lsb;
        w_inst_nx        = inst_to_ifetch;
        w_idx_nx         = r_idx;
        w_buf_nx         = r_buf;

        // In READ, r_idx counts addresses issued; mem_din carries byte r_idx-1.
        w_buf_cap = r_buf;
        case (r_idx)
            3'd1:    w_buf_cap[7:0]   = mem_din;
            3'd2:    w_buf_cap[15:8]  = mem_din;
            3'd3:    w_buf_cap[23:16] = mem_din;
            3'd4:    w_buf_cap[31:24] = mem_din;
            default: ;
        endcase

        case (r_idx[1:0])
            2'd0:    w_wr_byte = r_data[7:0];
            2'd1:    w_wr_byte = r_data[15:8];
            2'd2:    w_wr_byte = r_data[23:16];
            default: w_wr_byte = r_data[31:24];
        endcase

        case (r_state)
            IDLE: begin
                if (w_take) begin
                    w_mem_a_nx = w_req_addr;
                    w_buf_nx   = 32'd0;
                    w_idx_nx   = 3'd0;
                    // Byte 0 of a store goes out in the very first cycle.
                    if (w_req_store && !w_io_stall) begin
                        w_mem_dout_nx = data_from_lsb[7:0];
                        w_mem_wr_nx   = 1'b1;
                        w_idx_nx      = 3'd1;
                    end
                end
            end
            READ: begin
                w_buf_nx = w_buf_cap;
                w_idx_nx = r_idx + 3'd1;
                // Hold the last address rather than touch a byte nobody asked for.
                if (r_idx + 3'd1 < r_n)
                    w_mem_a_nx = r_addr + {29'd0, r_idx} + 32'd1;
                if (!rollback_from_rob && r_idx == r_n) begin
                    if (r_is_lsb) begin
                        w_valid_lsb_nx   = 1'b1;
                        w_data_to_lsb_nx = extend(r_op, w_buf_cap);
                    end else begin
                        w_valid_if_nx = 1'b1;
                        w_inst_nx     = w_buf_cap;
                    end
                end
            end
            WRITE: begin
                // A committed store always completes, rollback or not.
                if (r_idx == r_n) begin
                    w_valid_lsb_nx   = 1'b1;
                    w_data_to_lsb_nx = 32'd0;
                end else if (!w_io_stall) begin
                    w_mem_a_nx    = r_addr + {29'd0, r_idx};
                    w_mem_dout_nx = w_wr_byte;
                    w_mem_wr_nx   = 1'b1;
                    w_idx_nx      = r_idx + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and request latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_a           <= 32'd0;
            mem_dout        <= 8'd0;
            mem_wr          <= 1'b0;
            valid_to_lsb    <= 1'b0;
            valid_to_ifetch <= 1'b0;
            data_to_lsb     <= 32'd0;
            inst_to_ifetch  <= 32'd0;
            r_addr          <= 32'd0;
            r_data          <= 32'd0;
            r_buf           <= 32'd0;
            r_op            <= 4'd0;
            r_is_lsb        <= 1'b0;
            r_n             <= 3'd0;
            r_idx           <= 3'd0;
        end else if (rdy) begin
            mem_a           <= w_mem_a_nx;
            mem_dout        <= w_mem_dout_nx;
            mem_wr          <= w_mem_wr_nx;
            valid_to_lsb    <= w_valid_lsb_nx;
            valid_to_ifetch <= w_valid_if_nx;
            data_to_lsb     <= w_data_to_lsb_nx;
            inst_to_ifetch  <= w_inst_nx;
            r_idx           <= w_idx_nx;
            r_buf           <= w_buf_nx;
            if (r_state == IDLE && w_take) begin
                r_addr   <= w_req_addr;
                r_data   <= data_from_lsb;
                r_op     <= w_req_op;
                r_is_lsb <= valid_from_lsb;
                r_n      <= nbytes(w_req_op);
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mem_ctrl
// Self-checking bench for mem_ctrl. A byte RAM model answers the bus; every
// request pushes its expected completion (source, data, cycle) and expected
// RAM writes (address, byte, cycle) into scoreboard queues, and a monitor on
// the falling edge pops and compares them as the DUT produces them.
// ---------------------------------------------------------------------------
module tb_mem_ctrl;

    localparam logic [3:0] LB  = 4'd0;
    localparam logic [3:0] LH  = 4'd1;
    localparam logic [3:0] LW  = 4'd2;
    localparam logic [3:0] LBU = 4'd3;
    localparam logic [3:0] LHU = 4'd4;
    localparam logic [3:0] SB  = 4'd5;
    localparam logic [3:0] SH  = 4'd6;
    localparam logic [3:0] SW  = 4'd7;

    typedef struct { logic src_lsb; logic [31:0] data; int cyc; } rsp_t;
    typedef struct { logic [31:0] addr; logic [7:0] data; int cyc; } wr_t;

    logic        clk = 1'b0, rst = 1'b1, rdy = 1'b1;
    logic        rollback_from_rob = 1'b0, io_buffer_full = 1'b0;
    logic [7:0]  mem_din, mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        valid_from_lsb = 1'b0;
    logic [3:0]  inst_type_from_lsb = 4'd0;
    logic [31:0] addr_from_lsb = 32'd0, data_from_lsb = 32'd0;
    logic        valid_to_lsb;
    logic [31:0] data_to_lsb;
    logic        valid_from_ifetch = 1'b0;
    logic [31:0] addr_from_ifetch = 32'd0;
    logic        valid_to_ifetch;
    logic [31:0] inst_to_ifetch;

    mem_ctrl dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .rollback_from_rob(rollback_from_rob), .io_buffer_full(io_buffer_full),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .valid_from_lsb(valid_from_lsb), .inst_type_from_lsb(inst_type_from_lsb),
        .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
        .valid_to_lsb(valid_to_lsb), .data_to_lsb(data_to_lsb),
        .valid_from_ifetch(valid_from_ifetch), .addr_from_ifetch(addr_from_ifetch),
        .valid_to_ifetch(valid_to_ifetch), .inst_to_ifetch(inst_to_ifetch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: read data for the address of the previous cycle.
    logic [7:0] ram [0:262143];
    always @(posedge clk) begin
        if (rst) begin
            mem_din        <= 8'd0;
            ram[18'h00000] <= 8'h13; ram[18'h00001] <= 8'h05;
            ram[18'h00002] <= 8'h00; ram[18'h00003] <= 8'h00;
            ram[18'h00100] <= 8'h78; ram[18'h00101] <= 8'h56;
            ram[18'h00102] <= 8'h34; ram[18'h00103] <= 8'h12;
            ram[18'h00200] <= 8'h80; ram[18'h00201] <= 8'hFF;
            ram[18'h00300] <= 8'h11; ram[18'h00301] <= 8'h22;
            ram[18'h00302] <= 8'h33; ram[18'h00303] <= 8'h44;
            ram[18'h3FFFE] <= 8'hAA; ram[18'h3FFFF] <= 8'hBB;
        end else begin
            mem_din <= ram[mem_a[17:0]];
            if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
        end
    end

    int   n_checks = 0, n_errors = 0;
    rsp_t exp_q[$];
    wr_t  wr_q[$];
    int   exp_lsb = 0, exp_if = 0, n_lsb_rsp = 0, n_if_rsp = 0;
    int   t0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Monitor: every pulse and every RAM write must match the scoreboard head.
    rsp_t m_rsp;
    wr_t  m_wr;
    always @(negedge clk) begin
        if (!rst) begin
            if (valid_to_lsb || valid_to_ifetch) begin
                if (exp_q.size() == 0) begin
                    check("spurious_rsp", {31'd0, valid_to_lsb | valid_to_ifetch}, 32'd0);
                end else begin
                    m_rsp = exp_q.pop_front();
                    check("rsp_src", {30'd0, valid_to_lsb, valid_to_ifetch},
                          m_rsp.src_lsb ? 32'd2 : 32'd1);
                    check("rsp_data", valid_to_lsb ? data_to_lsb : inst_to_ifetch, m_rsp.data);
                    check("rsp_cycle", cyc, m_rsp.cyc);
                    if (valid_to_lsb) n_lsb_rsp++;
                    else n_if_rsp++;
                end
            end
            if (mem_wr) begin
                if (wr_q.size() == 0) begin
                    check("spurious_wr", mem_a, 32'hFFFF_FFFF);
                end else begin
                    m_wr = wr_q.pop_front();
                    check("wr_addr", mem_a, m_wr.addr);
                    check("wr_data", {24'd0, mem_dout}, {24'd0, m_wr.data});
                    check("wr_cycle", cyc, m_wr.cyc);
                end
            end
        end
    end

    function automatic int nbytes(input logic [3:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    // Drive an LSB request at a falling edge; the next rising edge is T0.
    // 'extra' is the number of stalled/frozen cycles the caller will inject.
    task automatic issue_lsb(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_data,
                             input int extra);
        int   n;
        rsp_t r;
        wr_t  w;
        @(negedge clk);
        t0 = cyc;
        valid_from_lsb     = 1'b1;
        inst_type_from_lsb = op;
        addr_from_lsb      = addr;
        data_from_lsb      = data;
        n = nbytes(op);
        r.src_lsb = 1'b1;
        r.data    = exp_data;
        if (op == SB || op == SH || op == SW) begin
            for (int i = 0; i < n; i++) begin
                w.addr = addr + 32'(i);
                w.data = data[8*i +: 8];
                w.cyc  = t0 + 1 + extra + i;
                wr_q.push_back(w);
            end
            r.cyc = t0 + n + 1 + extra;
        end else begin
            r.cyc = t0 + n + 2 + extra;
        end
        exp_q.push_back(r);
        exp_lsb++;
    endtask

    task automatic issue_if(input logic [31:0] addr, input logic [31:0] exp_word);
        rsp_t r;
        @(negedge clk);
        t0 = cyc;
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = addr;
        r.src_lsb = 1'b0;
        r.data    = exp_word;
        r.cyc     = t0 + 6;
        exp_q.push_back(r);
        exp_if++;
    endtask

    task automatic wait_lsb();
        for (int k = 0; k < 60 && n_lsb_rsp < exp_lsb; k++) begin
            @(negedge clk);
            #1;
        end
        if (n_lsb_rsp < exp_lsb) check("lsb_timeout", n_lsb_rsp, exp_lsb);
        valid_from_lsb = 1'b0;
    endtask

    task automatic wait_if();
        for (int k = 0; k < 60 && n_if_rsp < exp_if; k++) begin
            @(negedge clk);
            #1;
        end
        if (n_if_rsp < exp_if) check("if_timeout", n_if_rsp, exp_if);
        valid_from_ifetch = 1'b0;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_mem_a"}, mem_a, 32'd0);
        check({tag, "_mem_wr"}, {31'd0, mem_wr}, 32'd0);
        check({tag, "_mem_dout"}, {24'd0, mem_dout}, 32'd0);
        check({tag, "_valid_lsb"}, {31'd0, valid_to_lsb}, 32'd0);
        check({tag, "_valid_if"}, {31'd0, valid_to_ifetch}, 32'd0);
        check({tag, "_data_lsb"}, data_to_lsb, 32'd0);
        check({tag, "_inst"}, inst_to_ifetch, 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("reset");

        // LW with address sequence on the bus.
        issue_lsb(LW, 32'h100, 32'd0, 32'h1234_5678, 0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("lw_addr", mem_a, 32'h100 + 32'(j - 1));
            check("lw_rd", {31'd0, mem_wr}, 32'd0);
        end
        wait_lsb();

        // Sign and zero extension, back to back.
        issue_lsb(LB,  32'h200, 32'd0, 32'hFFFF_FF80, 0); wait_lsb();
        issue_lsb(LBU, 32'h200, 32'd0, 32'h0000_0080, 0); wait_lsb();
        issue_lsb(LH,  32'h200, 32'd0, 32'hFFFF_FF80, 0); wait_lsb();
        issue_lsb(LHU, 32'h200, 32'd0, 32'h0000_FF80, 0); wait_lsb();

        // SH writes two bytes; the next two bytes keep their old contents.
        issue_lsb(SH, 32'h300, 32'hAABB_CCDD, 32'd0, 0);         wait_lsb();
        issue_lsb(LW, 32'h300, 32'd0,         32'h4433_CCDD, 0); wait_lsb();

        // Both ports request together: LSB first, fetch right after.
        begin
            rsp_t r;
            @(negedge clk);
            t0 = cyc;
            valid_from_lsb     = 1'b1;
            inst_type_from_lsb = LB;
            addr_from_lsb      = 32'h200;
            valid_from_ifetch  = 1'b1;
            addr_from_ifetch   = 32'h0;
            r.src_lsb = 1'b1; r.data = 32'hFFFF_FF80; r.cyc = t0 + 3;
            exp_q.push_back(r);
            r.src_lsb = 1'b0; r.data = 32'h0000_0513; r.cyc = t0 + 10;
            exp_q.push_back(r);
            exp_lsb++;
            exp_if++;
        end
        wait_lsb();
        wait_if();

        // Fetch flushed in cycle 3: no pulse; a later fetch works normally.
        @(negedge clk);
        valid_from_ifetch = 1'b1;
        addr_from_ifetch  = 32'h100;
        repeat (3) @(negedge clk);
        rollback_from_rob = 1'b1;
        valid_from_ifetch = 1'b0;
        @(negedge clk);
        rollback_from_rob = 1'b0;
        repeat (8) @(negedge clk);
        check("rb_if_no_pulse", n_if_rsp, exp_if);
        issue_if(32'h100, 32'h1234_5678);
        wait_if();

        // Rollback during a store does not stop it.
        issue_lsb(SW, 32'h400, 32'hDEAD_BEEF, 32'd0, 0);
        repeat (2) @(negedge clk);
        rollback_from_rob = 1'b1;
        @(negedge clk);
        rollback_from_rob = 1'b0;
        wait_lsb();
        issue_lsb(LW, 32'h400, 32'd0, 32'hDEAD_BEEF, 0); wait_lsb();

        // IO write held off for three cycles by a full UART buffer.
        io_buffer_full = 1'b1;
        issue_lsb(SB, 32'h0003_0000, 32'h0000_005A, 32'd0, 3);
        repeat (3) @(negedge clk);
        io_buffer_full = 1'b0;
        wait_lsb();

        // rdy low for two edges freezes the transaction.
        issue_lsb(LBU, 32'h200, 32'd0, 32'h0000_0080, 2);
        @(negedge clk);
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        rdy = 1'b1;
        wait_lsb();

        // Address arithmetic wraps at 2^32.
        issue_lsb(LW, 32'hFFFF_FFFE, 32'd0, 32'h0513_BBAA, 0);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            check("wrap_addr", mem_a, 32'hFFFF_FFFE + 32'(j - 1));
        end
        wait_lsb();

        // Reset in the middle of a load clears outputs at once and drops it.
        issue_lsb(LW, 32'h100, 32'd0, 32'h1234_5678, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check_outputs_zero("mid_rst");
        exp_q.delete();
        exp_lsb--;
        valid_from_lsb = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("rst_no_pulse", n_lsb_rsp, exp_lsb);
        issue_lsb(LW, 32'h100, 32'd0, 32'h1234_5678, 0); wait_lsb();

        repeat (5) @(negedge clk);
        check("rsp_queue_empty", exp_q.size(), 32'd0);
        check("wr_queue_empty", wr_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
